rb_operand_scoreboard: RTL and testbench

ID-stage issue controller that sequences the RB operand multiplexer. It decodes which source field (rb or rf) the instruction in ID reads and drives the mux select. A per-register pending-write scoreboard stalls ID until the selected source, and the destination, have no write in flight. It sits between the decoder and the ID/EX pipeline register and receives writeback notifications from the WB stage.

---
 rtl/rb_operand_scoreboard_if.sv | 32 +++
 rtl/rb_operand_scoreboard.sv | 75 +++++++
 tb/tb_rb_operand_scoreboard.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/rb_operand_scoreboard_if.sv
// Decoder/WB-facing bundle for the RB operand scoreboard.
// master = decoder + WB side (drives the instruction fields), slave = scoreboard.
interface rb_operand_scoreboard_if #(
  parameter int REGS = 16,
  parameter int AW   = 4
);
  logic            id_valid;
  logic            use_rf;
  logic [AW-1:0]   rb_addr;
  logic [AW-1:0]   rf_addr;
  logic [AW-1:0]   ra_addr;
  logic [AW-1:0]   rd_addr;
  logic            rd_we;
  logic            wb_we;
  logic [AW-1:0]   wb_addr;
  logic            rb_selector;
  logic [AW-1:0]   src_addr;
  logic            stall;
  logic            issue;
  logic [REGS-1:0] pending;
  logic [15:0]     stall_cnt;

  modport master (
    output id_valid, use_rf, rb_addr, rf_addr, ra_addr, rd_addr, rd_we, wb_we, wb_addr,
    input  rb_selector, src_addr, stall, issue, pending, stall_cnt
  );

  modport slave (
    input  id_valid, use_rf, rb_addr, rf_addr, ra_addr, rd_addr, rd_we, wb_we, wb_addr,
    output rb_selector, src_addr, stall, issue, pending, stall_cnt
  );
endinterface

// File: rtl/rb_operand_scoreboard.sv
// ID-stage RB/RF operand select plus pending-write scoreboard (RAW on ra/src, WAW on rd).
// Optional saturating stall counter enabled by defining RB_SB_STALL_CNT_EN.
module rb_operand_scoreboard #(
  parameter int N    = 32,
  parameter int REGS = 16,
  parameter int AW   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  rb_operand_scoreboard_if.slave  sb
);

  if ((2**AW < REGS) || (N < 1)) begin : g_param_chk
    $error("rb_operand_scoreboard: AW too small for REGS or bad N");
  end

  logic [REGS-1:0] pending_q, pending_d;
  logic [REGS-1:0] wb_hit, eff;
  logic [AW-1:0]   src;
  logic            hazard, issue;

  // Out-of-range addresses match no index, so they read as not pending and never set.
  function automatic logic lookup(input logic [REGS-1:0] v, input logic [AW-1:0] a);
    lookup = 1'b0;
    for (int i = 0; i < REGS; i++)
      if (a == AW'(i)) lookup = v[i];
  endfunction

  always_comb begin
    src = sb.use_rf ? sb.rf_addr : sb.rb_addr;
    for (int i = 0; i < REGS; i++) begin
      wb_hit[i] = sb.wb_we && (sb.wb_addr == AW'(i));
      eff[i]    = pending_q[i] & ~wb_hit[i];
    end
    hazard = sb.id_valid & (lookup(eff, sb.ra_addr) | lookup(eff, src) |
                            (sb.rd_we & lookup(eff, sb.rd_addr)));
    issue  = sb.id_valid & ~hazard;
    pending_d = pending_q;
    // Clear first, then set, so a same-cycle issue to the WB register stays pending.
    for (int i = 0; i < REGS; i++) begin
      if (wb_hit[i]) pending_d[i] = 1'b0;
      if (issue && sb.rd_we && (sb.rd_addr == AW'(i))) pending_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

  assign sb.rb_selector = sb.use_rf;
  assign sb.src_addr    = src;
  assign sb.stall       = hazard;
  assign sb.issue       = issue;
  assign sb.pending     = pending_q;

`ifdef RB_SB_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hazard && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign sb.stall_cnt = stall_cnt_q;
`else
  assign sb.stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_rb_operand_scoreboard.sv
// Directed bench for rb_operand_scoreboard: vector table for the combinational select/hazard
// path plus sequences for reset, RAW stall, set/clear collision and the stall counter.
module tb_rb_operand_scoreboard;
  logic clk, rst;
  int   checks = 0;
  int   errors = 0;

  rb_operand_scoreboard_if #(.REGS(16), .AW(4)) sbi ();

  rb_operand_scoreboard #(.N(32), .REGS(16), .AW(4)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sbi.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       vld;
    logic       use_rf;
    logic [3:0] ra, rb, rf, rd;
    logic       rd_we;
    logic       wb_we;
    logic [3:0] wb;
    logic       e_sel;
    logic [3:0] e_src;
    logic       e_stall;
    logic       e_issue;
  } vec_t;

  vec_t tv[11];

`ifdef RB_SB_STALL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    sbi.id_valid = 1'b0; sbi.use_rf = 1'b0;
    sbi.ra_addr = 4'd0; sbi.rb_addr = 4'd0; sbi.rf_addr = 4'd0; sbi.rd_addr = 4'd0;
    sbi.rd_we = 1'b0; sbi.wb_we = 1'b0; sbi.wb_addr = 4'd0;
  endtask

  // Instruction that reads r0/r0 and writes rd
  task automatic set_instr(input logic [3:0] rd);
    idle();
    sbi.id_valid = 1'b1; sbi.rd_addr = rd; sbi.rd_we = 1'b1;
  endtask

  initial begin
    //            vld rf  ra  rb  rf  rd  we  wbwe wb  sel src stl iss
    tv[0]  = '{1'b0,1'b0,4'd0,4'd3,4'd9,4'd0,1'b0,1'b0,4'd0, 1'b0,4'd3,1'b0,1'b0};
    tv[1]  = '{1'b0,1'b1,4'd0,4'd3,4'd9,4'd0,1'b0,1'b0,4'd0, 1'b1,4'd9,1'b0,1'b0};
    tv[2]  = '{1'b1,1'b0,4'd0,4'd2,4'd5,4'd1,1'b1,1'b0,4'd0, 1'b0,4'd2,1'b0,1'b1};
    tv[3]  = '{1'b1,1'b1,4'd0,4'd2,4'd5,4'd1,1'b1,1'b0,4'd0, 1'b1,4'd5,1'b1,1'b0};
    tv[4]  = '{1'b1,1'b0,4'd7,4'd2,4'd5,4'd1,1'b0,1'b0,4'd0, 1'b0,4'd2,1'b1,1'b0};
    tv[5]  = '{1'b1,1'b0,4'd0,4'd2,4'd5,4'd7,1'b1,1'b0,4'd0, 1'b0,4'd2,1'b1,1'b0};
    tv[6]  = '{1'b1,1'b0,4'd0,4'd2,4'd5,4'd7,1'b0,1'b0,4'd0, 1'b0,4'd2,1'b0,1'b1};
    tv[7]  = '{1'b1,1'b1,4'd0,4'd2,4'd5,4'd1,1'b0,1'b1,4'd5, 1'b1,4'd5,1'b0,1'b1};
    tv[8]  = '{1'b1,1'b0,4'd7,4'd2,4'd5,4'd1,1'b0,1'b1,4'd5, 1'b0,4'd2,1'b1,1'b0};
    tv[9]  = '{1'b0,1'b0,4'd7,4'd5,4'd5,4'd7,1'b1,1'b0,4'd0, 1'b0,4'd5,1'b0,1'b0};
    tv[10] = '{1'b1,1'b0,4'd0,4'd5,4'd2,4'd1,1'b0,1'b1,4'd7, 1'b0,4'd5,1'b1,1'b0};

    idle();
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;

    // Async reset: load pending[5], then reset between edges
    @(negedge clk); set_instr(4'd5);
    @(negedge clk); idle(); #1;
    chk("pre_rst_pending", 32'(sbi.pending), 32'h0020);
    #1 rst = 1'b1; #1;
    chk("rst_pending", 32'(sbi.pending), 32'h0);
    chk("rst_stall", 32'(sbi.stall), 32'h0);
    chk("rst_stall_cnt", 32'(sbi.stall_cnt), 32'h0);
    @(negedge clk); rst = 1'b0;

    // Known state for the table: pending = {7,5}
    @(negedge clk); set_instr(4'd5);
    @(negedge clk); set_instr(4'd7);
    @(negedge clk); idle(); #1;
    chk("tbl_pending", 32'(sbi.pending), 32'h00A0);

    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      sbi.id_valid = tv[k].vld; sbi.use_rf = tv[k].use_rf;
      sbi.ra_addr = tv[k].ra; sbi.rb_addr = tv[k].rb; sbi.rf_addr = tv[k].rf;
      sbi.rd_addr = tv[k].rd; sbi.rd_we = tv[k].rd_we;
      sbi.wb_we = tv[k].wb_we; sbi.wb_addr = tv[k].wb;
      #1;
      chk($sformatf("v%0d_sel", k),   32'(sbi.rb_selector), 32'(tv[k].e_sel));
      chk($sformatf("v%0d_src", k),   32'(sbi.src_addr),    32'(tv[k].e_src));
      chk($sformatf("v%0d_stall", k), 32'(sbi.stall),       32'(tv[k].e_stall));
      chk($sformatf("v%0d_issue", k), 32'(sbi.issue),       32'(tv[k].e_issue));
      #1 idle();
    end
    #1 chk("tbl_pending_kept", 32'(sbi.pending), 32'h00A0);

    // Set/clear collision on r7: issue bypasses the WAW, bit stays set
    @(negedge clk); set_instr(4'd7); sbi.wb_we = 1'b1; sbi.wb_addr = 4'd7; #1;
    chk("coll_issue", 32'(sbi.issue), 32'h1);
    chk("coll_stall", 32'(sbi.stall), 32'h0);
    @(negedge clk); idle(); #1;
    chk("coll_pending", 32'(sbi.pending), 32'h00A0);

    // WB to a non-pending register is harmless
    @(negedge clk); sbi.wb_we = 1'b1; sbi.wb_addr = 4'd3;
    @(negedge clk); idle(); #1;
    chk("wb_nonpend", 32'(sbi.pending), 32'h00A0);
    @(negedge clk); sbi.wb_we = 1'b1; sbi.wb_addr = 4'd5;
    @(negedge clk); sbi.wb_addr = 4'd7;
    @(negedge clk); idle(); #1;
    chk("wb_clear_all", 32'(sbi.pending), 32'h0);

    // RAW: producer rd=5 at t, consumer on rf=5 stalls t+1..t+3, WB at t+4
    @(negedge clk); set_instr(4'd5);
    @(negedge clk);
    idle(); sbi.id_valid = 1'b1; sbi.use_rf = 1'b1; sbi.rf_addr = 4'd5;
    sbi.rb_addr = 4'd2; sbi.rd_addr = 4'd6; sbi.rd_we = 1'b1; #1;
    chk("raw_pending", 32'(sbi.pending), 32'h0020);
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      chk($sformatf("raw_stall%0d", c), 32'(sbi.stall), 32'h1);
      chk($sformatf("raw_issue%0d", c), 32'(sbi.issue), 32'h0);
    end
    @(negedge clk); sbi.wb_we = 1'b1; sbi.wb_addr = 4'd5; #1;
    chk("raw_wb_stall", 32'(sbi.stall), 32'h0);
    chk("raw_wb_issue", 32'(sbi.issue), 32'h1);
    @(negedge clk); idle(); #1;
    chk("raw_after", 32'(sbi.pending), 32'h0040);

    // Counter: clean reset, then a 10-cycle and a 70000-cycle stall on r5
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; set_instr(4'd5);
    @(negedge clk);
    idle(); sbi.id_valid = 1'b1; sbi.use_rf = 1'b1; sbi.rf_addr = 4'd5;
    sbi.rd_addr = 4'd6; sbi.rd_we = 1'b1; #1;
    chk("cnt_start", 32'(sbi.stall_cnt), 32'h0);
    chk("cnt_stall", 32'(sbi.stall), 32'h1);
    repeat (10) @(posedge clk);
    @(negedge clk); #1;
    chk("cnt_10", 32'(sbi.stall_cnt), CNT_EN ? 32'd10 : 32'd0);
    repeat (70000) @(posedge clk);
    @(negedge clk); #1;
    chk("cnt_sat", 32'(sbi.stall_cnt), CNT_EN ? 32'hFFFF : 32'd0);
    chk("cnt_still_stall", 32'(sbi.stall), 32'h1);

    // Reset during the stall: held instruction issues right after release
    #1 rst = 1'b1; #1;
    chk("mid_rst_pending", 32'(sbi.pending), 32'h0);
    chk("mid_rst_cnt", 32'(sbi.stall_cnt), 32'h0);
    chk("mid_rst_stall", 32'(sbi.stall), 32'h0);
    @(negedge clk); rst = 1'b0; #1;
    chk("post_rst_issue", 32'(sbi.issue), 32'h1);
    @(negedge clk); idle(); #1;
    chk("post_rst_pending", 32'(sbi.pending), 32'h0040);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
